// File: rtl/crc_sig_pkg.sv
// rtl/crc_sig_pkg.sv - shared types, constants and MISR step function for the CRC signature path
package crc_sig_pkg;

    localparam int SIG_W = 32;

    // x^32 + x^16 + x^11 + x^4 + 1; bit 0 is implied because stage 0 always takes the feedback
    localparam logic [SIG_W-1:0] POLY_DEFAULT = 32'h0001_0811;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        CHECK  = 2'd1,
        REPORT = 2'd2
    } state_t;

    // One MISR step: shift up by one, fold the data word in, and feed q[msb] back into the tap stages.
    // Shared with the generator-side model so both ends compact identically.
    function automatic logic [SIG_W-1:0] misr_next(
        input logic [SIG_W-1:0] q,
        input logic [SIG_W-1:0] d,
        input logic [SIG_W-1:0] poly
    );
        logic [SIG_W-1:0] n;
        n[0] = q[SIG_W-1] ^ d[0];
        for (int i = 1; i < SIG_W; i++) begin
            n[i] = q[i-1] ^ d[i] ^ (poly[i] & q[SIG_W-1]);
        end
        return n;
    endfunction

endpackage

// File: rtl/crc_misr_reg.sv
// rtl/crc_misr_reg.sv - MISR register with seed-load and update enables
//
// Ports:
//   clk       rising-edge clock
//   load_seed reload SEED (takes priority over update)
//   update    compact d into the register
//   d         data word to compact
//   q         current MISR contents
module crc_misr_reg
    import crc_sig_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = POLY_DEFAULT,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             load_seed,
    input  logic             update,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (load_seed) begin
            q <= SEED;
        end else if (update) begin
            q <= misr_next(q, d, POLY);
        end
    end

endmodule

// File: rtl/crc_misr_sig_checker.sv
// rtl/crc_misr_sig_checker.sv - compacts frame data into a MISR and checks it against the trailing signature beat
//
// Ports:
//   CK         rising-edge clock
//   RESET      synchronous active-high reset
//   in_valid   beat offered
//   in_ready   beat can be accepted (low during CHECK and REPORT)
//   in_data    data word, or expected signature when in_last=1
//   in_last    beat carries the expected signature and ends the frame
//   sig_out    current MISR contents
//   busy       frame in progress
//   done       one-cycle pulse when pass/fail_count reflect the finished frame
//   pass       result of the last completed frame, held until the next done
//   fail_count saturating count of failing frames
module crc_misr_sig_checker
    import crc_sig_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = POLY_DEFAULT,
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter int               CNT_W = 16
) (
    input  logic             CK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic [WIDTH-1:0] sig_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count
);

    state_t           state;
    logic [WIDTH-1:0] exp_reg;
    logic             match;
    logic             accept;
    logic             misr_update;
    logic             misr_load;

    // in_ready is only ever high in RUN; the state term keeps the enable self-contained
    assign accept      = in_valid & in_ready & (state == RUN);
    assign misr_update = accept & ~in_last;
    // The MISR returns to SEED on reset (aborting any frame) and when a result is reported
    assign misr_load   = RESET | (state == REPORT);

    crc_misr_reg #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk       (CK),
        .load_seed (misr_load),
        .update    (misr_update),
        .d         (in_data),
        .q         (sig_out)
    );

    always_ff @(posedge CK) begin
        if (RESET) begin
            state      <= RUN;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= '0;
            exp_reg    <= '0;
            match      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (in_last) begin
                            exp_reg  <= in_data;
                            in_ready <= 1'b0;
                            state    <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    match <= (sig_out == exp_reg);
                    state <= REPORT;
                end
                REPORT: begin
                    done     <= 1'b1;
                    pass     <= match;
                    if (!match && (fail_count != {CNT_W{1'b1}})) begin
                        fail_count <= fail_count + CNT_W'(1);
                    end
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= RUN;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_misr_sig_checker.sv
// tb/tb_crc_misr_sig_checker.sv - self-checking bench for crc_misr_sig_checker
module tb_crc_misr_sig_checker;

    localparam int          W     = 32;
    localparam int          CW    = 3;
    localparam logic [31:0] P     = 32'h0001_0811;
    localparam logic [31:0] S     = 32'h0000_0000;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic          CK = 1'b0;
    logic          RESET = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic [W-1:0]  sig_out;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] fail_count;

    crc_misr_sig_checker #(
        .WIDTH (W),
        .POLY  (P),
        .SEED  (S),
        .CNT_W (CW)
    ) dut (
        .CK         (CK),
        .RESET      (RESET),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .sig_out    (sig_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_count (fail_count)
    );

    always #5 CK = ~CK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic          exp_pass;
        logic [CW-1:0] exp_cnt;
    } result_t;

    result_t       sb[$];
    logic [31:0]   model_sig = S;
    logic [CW-1:0] model_cnt = '0;
    int            stall = 0;

    // Reference MISR in shift-register form: shift up, xor data, xor taps (with stage 0) on carry-out
    function automatic logic [31:0] ref_step(input logic [31:0] q, input logic [31:0] d);
        logic [31:0] fb;
        fb = q[31] ? (P | 32'h1) : 32'h0;
        return (q << 1) ^ d ^ fb;
    endfunction

    // Result monitor: every done must match the oldest queued expectation, follow exactly two
    // stalled cycles, and leave the MISR back at SEED.
    always @(negedge CK) begin
        if (in_ready === 1'b0) begin
            stall++;
        end else begin
            if (!RESET && done === 1'b1) begin
                result_t r;
                check("stall_len", 32'(stall), 32'd2);
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    r = sb.pop_front();
                    check("pass", {31'd0, pass}, {31'd0, r.exp_pass});
                    check("fail_count", {29'd0, fail_count}, {29'd0, r.exp_cnt});
                    check("sig_after_report", sig_out, S);
                    check("busy_after_report", {31'd0, busy}, 32'd0);
                end
            end
            stall = 0;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic last);
        int w;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        w = 0;
        while (in_ready !== 1'b1) begin
            @(negedge CK);
            w++;
            if (w > 20) begin
                check("ready_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge CK);
        #1;
    endtask

    task automatic send_frame(input int n, input logic [3:0][31:0] d, input logic [31:0] last,
                              input logic use_model, input logic exp_pass, input logic hold);
        logic [31:0] l;
        result_t     r;
        for (int i = 0; i < n; i++) begin
            send_beat(d[i], 1'b0);
            model_sig = ref_step(model_sig, d[i]);
            check("sig_beat", sig_out, model_sig);
            check("busy_beat", {31'd0, busy}, 32'd1);
        end
        l = use_model ? model_sig : last;
        send_beat(l, 1'b1);
        check("ready_after_last", {31'd0, in_ready}, 32'd0);
        if (!exp_pass && model_cnt != CMAX) model_cnt = model_cnt + 1'b1;
        r.exp_pass = exp_pass;
        r.exp_cnt  = model_cnt;
        sb.push_back(r);
        model_sig = S;
        if (!hold) in_valid = 1'b0;
    endtask

    typedef struct {
        int               n;
        logic [3:0][31:0] d;
        logic [31:0]      last;
        logic             use_model;
        logic             exp_pass;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1, {32'h0, 32'h0, 32'h0, 32'h0000_0001}, 32'h0000_0001, 1'b0, 1'b1};
        vecs[1] = '{2, {32'h0, 32'h0, 32'h0000_0000, 32'h8000_0000}, 32'h0001_0811, 1'b0, 1'b1};
        vecs[2] = '{2, {32'h0, 32'h0, 32'h0000_0000, 32'h8000_0000}, 32'h0001_0810, 1'b0, 1'b0};
        vecs[3] = '{0, {32'h0, 32'h0, 32'h0, 32'h0}, 32'h0000_0000, 1'b0, 1'b1};
        vecs[4] = '{0, {32'h0, 32'h0, 32'h0, 32'h0}, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[5] = '{3, {32'h0, 32'h0F0F_F0F0, 32'h1234_5678, 32'hDEAD_BEEF}, 32'h0, 1'b1, 1'b1};

        repeat (2) @(negedge CK);
        @(posedge CK);
        #1;
        RESET = 1'b0;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_cnt", {29'd0, fail_count}, 32'd0);
        check("rst_sig", sig_out, S);

        // Spot check of the hand-derived MISR values from the two-beat frame
        check("ref_step_a", ref_step(32'h0, 32'h8000_0000), 32'h8000_0000);
        check("ref_step_b", ref_step(32'h8000_0000, 32'h0), 32'h0001_0811);

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].n, vecs[v].d, vecs[v].last, vecs[v].use_model, vecs[v].exp_pass, 1'b0);
            repeat (2) @(negedge CK);
        end

        // Back-to-back with in_valid held: second frame's first beat waits out CHECK/REPORT
        send_frame(2, {32'h0, 32'h0, 32'h0000_00A5, 32'h0000_0003}, 32'h0, 1'b1, 1'b1, 1'b1);
        send_frame(1, {32'h0, 32'h0, 32'h0, 32'h0000_0007}, 32'h0000_0007, 1'b0, 1'b1, 1'b1);
        send_frame(2, {32'h0, 32'h0, 32'h1111_2222, 32'hFFFF_0000}, 32'h0, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge CK);

        // Reset after two data beats: frame aborted silently
        send_beat(32'h1234_0000, 1'b0);
        send_beat(32'h0000_5678, 1'b0);
        in_valid = 1'b0;
        @(negedge CK);
        RESET = 1'b1;
        @(posedge CK);
        #1;
        model_sig = S;
        model_cnt = '0;
        check("abort_sig", sig_out, S);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_cnt", {29'd0, fail_count}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge CK);
        RESET = 1'b0;
        repeat (2) @(negedge CK);
        send_frame(1, {32'h0, 32'h0, 32'h0, 32'h0000_0001}, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge CK);

        // Drive the counter to all-ones and beyond
        for (int k = 0; k < 9; k++) begin
            send_frame(0, {32'h0, 32'h0, 32'h0, 32'h0}, 32'h0000_00F0 + 32'(k), 1'b0, 1'b0, 1'b0);
        end
        repeat (3) @(negedge CK);

        begin
            int w;
            w = 0;
            while (sb.size() != 0 && w < 50) begin
                @(negedge CK);
                w++;
            end
            check("sb_drained", 32'(sb.size()), 32'd0);
        end
        check("cnt_saturated", {29'd0, fail_count}, {29'd0, CMAX});
        repeat (5) @(negedge CK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc_misr_sig_checker.md
Name: crc_misr_sig_checker

Overview:
- Receive end of the 32-bit CRC signature compaction path.
- Accepts a frame of 32-bit data words over a valid/ready handshake and compacts each non-final word into a MISR, using the same polynomial as the signature generator.
- The final beat of each frame carries the expected signature. The block compares it with the compacted value and reports pass or fail.
- Sits between the scan/CRC output bus and the test controller's result registers.

Parameters:
WIDTH, 32, data and signature width
POLY, 32'h0001_0811, feedback taps for x^32+x^16+x^11+x^4+1 (bit i set => q[31] fed back into stage i)
SEED, 32'h0000_0000, MISR value after reset and at the start of every frame
CNT_W, 16, width of the saturating fail counter

Ports:
CK  input  1  clock, rising edge
RESET  input  1  synchronous, active-high reset
in_valid  input  1  beat offered
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  data word, or expected signature when in_last=1
in_last  input  1  beat is the expected-signature beat; it ends the frame
sig_out  output  WIDTH  current MISR contents
busy  output  1  a frame is in progress (at least one data beat accepted, or in CHECK/REPORT)
done  output  1  one-cycle pulse when the frame result is valid
pass  output  1  result of the last completed frame; held until the next done
fail_count  output  CNT_W  number of failing frames, saturates at all-ones

Behaviour:
- Reset (RESET=1 at a CK edge): state RUN, MISR=SEED, in_ready=1, busy=0, done=0, pass=0, fail_count=0.
  - Reset mid-frame aborts the frame with no done pulse.
- Beat acceptance: a beat is accepted when in_valid & in_ready at a CK edge. in_data and in_last are sampled only on accepted beats.
- MISR update on an accepted beat with in_last=0, where d=in_data and q=current MISR:
  - next[0] = q[31] ^ d[0]
  - next[i] = q[i-1] ^ d[i] ^ (POLY[i] & q[31]), for i = 1..31
  - POLY[0] is ignored (stage 0 is always fed back).
- State RUN:
  - in_ready=1.
  - An accepted non-last beat updates the MISR and sets busy=1.
  - An accepted last beat latches in_data into exp_reg, sets busy=1 and moves to CHECK. The MISR is not updated by the last beat.
- State CHECK (1 cycle):
  - in_ready=0.
  - Register match = (MISR == exp_reg); move to REPORT.
- State REPORT (1 cycle):
  - in_ready=0, done=1, pass=match.
  - If !match, increment fail_count unless it is already all-ones.
  - MISR reloads SEED, busy=0, move to RUN.
- Latency: last beat accepted at edge n; CHECK registers the compare at edge n+1; done and pass are high after edge n+2 (the REPORT cycle).
- Throughput: one frame per (data beats + 3) cycles.
- Empty frame (last beat with no preceding data beats): the expected value is compared with SEED.
- sig_out reflects the MISR after every edge, including the SEED reload in REPORT.
- in_valid held high while in_ready=0: no beat is accepted and nothing changes.

Decomposition:
- Shared package crc_sig_pkg holds:
  - the POLY default constant;
  - the state enum {RUN, CHECK, REPORT};
  - the pure function misr_next(q, d, poly), which is also used by the generator-side model.
- One sub-module, crc_misr_reg: the WIDTH-bit MISR register with load-seed and update enables.
- crc_misr_sig_checker contains the FSM, exp_reg, compare and counters.

Test Plan:
- Reset, then frame [32'h0000_0001, last=32'h0000_0001] -> after the first beat sig_out=32'h0000_0001; done two cycles after the last beat; pass=1; fail_count=0.
- Frame [32'h8000_0000, 32'h0000_0000, last=32'h0001_0811] -> sig_out 32'h8000_0000 then 32'h0001_0811; pass=1.
- Same frame with last=32'h0001_0810 -> pass=0, fail_count=1; sig_out returns to SEED after REPORT.
- Empty frame: only last=32'h0000_0000 -> pass=1. Empty frame with last=32'hFFFF_FFFF -> pass=0.
- in_valid held high through CHECK/REPORT -> in_ready=0 for exactly 2 cycles; the next frame's first beat is accepted in the RUN cycle that follows, with no beat lost or duplicated.
- RESET asserted after 2 data beats -> no done pulse, sig_out=SEED, fail_count=0; the following frame checks correctly. Force fail_count to all-ones with a failing frame -> it stays at all-ones.
